// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: sequences PC redirection around the EX-stage branch/jump decision
// Defining BRANCH_STATS_EN adds saturating event counters statTaken/statNotTaken/statJump/statTimeout.
`ifndef Sequence
`define Sequence 2'b00
`endif
`ifndef Branch
`define Branch 2'b01
`endif
`ifndef Jump
`define Jump 2'b10
`endif
`ifndef NotBranch
`define NotBranch 2'b11
`endif
module branch_redirect_ctrl #(
  parameter int MAX_WAIT = 4
`ifdef BRANCH_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idValid,
  input  logic [1:0]       idChangeType,
  input  logic [1:0]       exBranchOrJump,
  input  logic             loadUseStall,
  output logic [1:0]       pcSel,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             busy,
  output logic             timeout
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] statTaken,
  output logic [CNT_W-1:0] statNotTaken,
  output logic [CNT_W-1:0] statJump,
  output logic [CNT_W-1:0] statTimeout
`endif
);
  localparam int W = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {RUN, BR_WAIT, REDIRECT} state_t;
  state_t state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic [1:0] sel_q, sel_n;
  // state, wait counter and latched redirect target select
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      sel_q <= `Sequence;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sel_q <= sel_n;
    end
  end
  // next state and pipeline control; outputs react in the same cycle as the ID/EX inputs
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sel_n     = sel_q;
    pcSel     = `Sequence;
    pcWrite   = 1'b1;
    ifidWrite = 1'b1;
    ifidFlush = 1'b0;
    idexFlush = 1'b0;
    timeout   = 1'b0;
    case (state)
      RUN: begin
        if (loadUseStall) begin
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          idexFlush = 1'b1;
        end else if (idValid && idChangeType == `Jump) begin
          pcSel     = `Jump;
          ifidFlush = 1'b1;
        end else if (idValid && idChangeType == `Branch) begin
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          state_n   = BR_WAIT;
          cnt_n     = '0;
        end
      end
      BR_WAIT: begin
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        idexFlush = 1'b1;
        case (exBranchOrJump)
          `Branch: begin
            state_n = REDIRECT;
            sel_n   = `Branch;
          end
          `Jump: begin
            state_n = REDIRECT;
            sel_n   = `Jump;
          end
          `NotBranch: state_n = RUN;
          default: begin
            if (cnt == W'(MAX_WAIT - 1)) begin
              timeout = 1'b1;
              state_n = RUN;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        endcase
      end
      REDIRECT: begin
        pcSel     = sel_q;
        ifidFlush = 1'b1;
        state_n   = RUN;
      end
      default: state_n = RUN;
    endcase
  end
  assign busy = state != RUN;
`ifdef BRANCH_STATS_EN
  logic ev_taken, ev_not, ev_jump;
  assign ev_taken = state == BR_WAIT && exBranchOrJump == `Branch;
  assign ev_not   = state == BR_WAIT && exBranchOrJump == `NotBranch;
  assign ev_jump  = state == RUN && !loadUseStall && idValid && idChangeType == `Jump;
  // saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      statTaken    <= '0;
      statNotTaken <= '0;
      statJump     <= '0;
      statTimeout  <= '0;
    end else begin
      if (ev_taken && !(&statTaken)) statTaken <= statTaken + 1'b1;
      if (ev_not && !(&statNotTaken)) statNotTaken <= statNotTaken + 1'b1;
      if (ev_jump && !(&statJump)) statJump <= statJump + 1'b1;
      if (timeout && !(&statTimeout)) statTimeout <= statTimeout + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed checks of branch_redirect_ctrl with MAX_WAIT=4
module tb_branch_redirect_ctrl;
  localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, JMP = 2'b10, NB = 2'b11;
  logic clk = 1'b0, rst = 1'b1, idValid = 1'b0, loadUseStall = 1'b0;
  logic [1:0] idChangeType = SEQ, exBranchOrJump = SEQ, pcSel;
  logic pcWrite, ifidWrite, ifidFlush, idexFlush, busy, timeout;
  int checks = 0, errors = 0;
`ifdef BRANCH_STATS_EN
  logic [15:0] statTaken, statNotTaken, statJump, statTimeout;
`endif
  always #5 clk = ~clk;
  branch_redirect_ctrl #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .idValid(idValid), .idChangeType(idChangeType),
    .exBranchOrJump(exBranchOrJump), .loadUseStall(loadUseStall), .pcSel(pcSel),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
    .idexFlush(idexFlush), .busy(busy), .timeout(timeout)
`ifdef BRANCH_STATS_EN
    , .statTaken(statTaken), .statNotTaken(statNotTaken), .statJump(statJump),
    .statTimeout(statTimeout)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic v, input logic [1:0] ct, input logic [1:0] ex,
                      input logic st, input logic [1:0] esel, input logic epw, input logic eiw,
                      input logic eif, input logic exf, input logic eb, input logic eto);
    idValid = v;
    idChangeType = ct;
    exBranchOrJump = ex;
    loadUseStall = st;
    @(negedge clk);
    chk({tag, ".pcSel"}, 32'(pcSel), 32'(esel));
    chk({tag, ".pcWrite"}, 32'(pcWrite), 32'(epw));
    chk({tag, ".ifidWrite"}, 32'(ifidWrite), 32'(eiw));
    chk({tag, ".ifidFlush"}, 32'(ifidFlush), 32'(eif));
    chk({tag, ".idexFlush"}, 32'(idexFlush), 32'(exf));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".timeout"}, 32'(timeout), 32'(eto));
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step("reset", 0, SEQ, SEQ, 0, SEQ, 1, 1, 0, 0, 0, 0);
    step("tk_id", 1, BR, SEQ, 0, SEQ, 0, 0, 0, 0, 0, 0);
    step("tk_wait", 0, SEQ, BR, 0, SEQ, 0, 0, 0, 1, 1, 0);
    step("tk_redir", 0, SEQ, SEQ, 0, BR, 1, 1, 1, 0, 1, 0);
    step("tk_run", 0, SEQ, SEQ, 0, SEQ, 1, 1, 0, 0, 0, 0);
    step("nt_id", 1, BR, SEQ, 0, SEQ, 0, 0, 0, 0, 0, 0);
    step("nt_wait", 0, SEQ, NB, 0, SEQ, 0, 0, 0, 1, 1, 0);
    step("nt_run", 0, SEQ, SEQ, 0, SEQ, 1, 1, 0, 0, 0, 0);
    step("js_stall1", 1, JMP, SEQ, 1, SEQ, 0, 0, 0, 1, 0, 0);
    step("js_stall2", 1, JMP, SEQ, 1, SEQ, 0, 0, 0, 1, 0, 0);
    step("js_jump", 1, JMP, SEQ, 0, JMP, 1, 1, 1, 0, 0, 0);
    step("js_run", 0, SEQ, SEQ, 0, SEQ, 1, 1, 0, 0, 0, 0);
    step("bs_stall", 1, BR, SEQ, 1, SEQ, 0, 0, 0, 1, 0, 0);
    step("exj_id", 1, BR, SEQ, 0, SEQ, 0, 0, 0, 0, 0, 0);
    step("exj_wait", 0, SEQ, JMP, 0, SEQ, 0, 0, 0, 1, 1, 0);
    step("exj_redir", 0, SEQ, SEQ, 0, JMP, 1, 1, 1, 0, 1, 0);
    step("to_id", 1, BR, SEQ, 0, SEQ, 0, 0, 0, 0, 0, 0);
    step("to_w1", 0, SEQ, SEQ, 0, SEQ, 0, 0, 0, 1, 1, 0);
    step("to_w2", 0, SEQ, SEQ, 1, SEQ, 0, 0, 0, 1, 1, 0);
    step("to_w3", 0, SEQ, SEQ, 0, SEQ, 0, 0, 0, 1, 1, 0);
    step("to_w4", 0, SEQ, SEQ, 0, SEQ, 0, 0, 0, 1, 1, 1);
    step("to_run", 0, SEQ, SEQ, 0, SEQ, 1, 1, 0, 0, 0, 0);
    step("rw_id", 1, BR, SEQ, 0, SEQ, 0, 0, 0, 0, 0, 0);
    step("rw_w1", 0, SEQ, SEQ, 0, SEQ, 0, 0, 0, 1, 1, 0);
    step("rw_w2", 0, SEQ, SEQ, 0, SEQ, 0, 0, 0, 1, 1, 0);
    rst = 1'b1;
    step("rw_rst", 0, SEQ, SEQ, 0, SEQ, 0, 0, 0, 1, 1, 0);
    rst = 1'b0;
    step("rw_run1", 0, SEQ, BR, 0, SEQ, 1, 1, 0, 0, 0, 0);
    step("rw_run2", 0, SEQ, SEQ, 0, SEQ, 1, 1, 0, 0, 0, 0);
    step("rw_run3", 0, SEQ, SEQ, 0, SEQ, 1, 1, 0, 0, 0, 0);
    step("rw_run4", 0, SEQ, SEQ, 0, SEQ, 1, 1, 0, 0, 0, 0);
`ifdef BRANCH_STATS_EN
    chk("st_clr_taken", 32'(statTaken), 0);
    for (int i = 0; i < 3; i++) begin
      step("st_tk_id", 1, BR, SEQ, 0, SEQ, 0, 0, 0, 0, 0, 0);
      step("st_tk_wait", 0, SEQ, BR, 0, SEQ, 0, 0, 0, 1, 1, 0);
      step("st_tk_redir", 0, SEQ, SEQ, 0, BR, 1, 1, 1, 0, 1, 0);
    end
    for (int i = 0; i < 2; i++) begin
      step("st_nt_id", 1, BR, SEQ, 0, SEQ, 0, 0, 0, 0, 0, 0);
      step("st_nt_wait", 0, SEQ, NB, 0, SEQ, 0, 0, 0, 1, 1, 0);
    end
    step("st_jump", 1, JMP, SEQ, 0, JMP, 1, 1, 1, 0, 0, 0);
    step("st_idle", 0, SEQ, SEQ, 0, SEQ, 1, 1, 0, 0, 0, 0);
    chk("statTaken", 32'(statTaken), 3);
    chk("statNotTaken", 32'(statNotTaken), 2);
    chk("statJump", 32'(statJump), 1);
    chk("statTimeout", 32'(statTimeout), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
